// File: rtl/kernel3_fifo_w64_srl_ctrl.sv
// First-word-fall-through FIFO built on a shift-register core, presenting the
// HLS ap_fifo handshake; occupancy and read address track the oldest word.
module kernel3_fifo_w64_srl_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  push, pop;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read  & if_read_ce  & empty_n_q;

  // Shift-register storage: new word enters at entry 0, older words move up.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
      if (count_q != '0) addr_d = addr_q + ADDR_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
      if (count_q > CNT_ONE) addr_d = addr_q - ADDR_ONE;
    end
    // Flags are registered copies of what the next occupancy implies.
    empty_n_d = (count_d != '0);
    full_n_d  = (count_d != CNT_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      addr_q    <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      count_q   <= count_d;
      addr_q    <= addr_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  assign if_dout           = mem_q[addr_q];
  assign if_empty_n        = empty_n_q;
  assign if_full_n         = full_n_q;
  assign if_num_data_valid = count_q;

endmodule

// File: doc/kernel3_fifo_w64_srl_ctrl.md
# kernel3_fifo_w64_srl_ctrl

First-word-fall-through FIFO with a shift-register storage core and the read/write control around it. The block tracks occupancy, drives the shift enable and read address into its internal SRL storage, and presents the HLS ap_fifo handshake on both sides. It sits on the inter-task streams of the kernel3 dataflow region: one producer task writes it and one consumer task reads it.

## Interface
- DATA_WIDTH, 64, payload width in bits
- ADDR_WIDTH, 1, read-address width; DEPTH must be ≤ 2^ADDR_WIDTH
- DEPTH, 2, number of entries; DEPTH ≥ 2
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_full_n  out  1  1 = space available for a write
- if_write_ce  in  1  write-side clock enable
- if_write  in  1  write request
- if_din  in  DATA_WIDTH  write data
- if_empty_n  out  1  1 = if_dout holds valid data
- if_read_ce  in  1  read-side clock enable
- if_read  in  1  read request (consumes the word on if_dout)
- if_dout  out  DATA_WIDTH  oldest stored word
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH

## Operation
- push = if_write & if_write_ce & if_full_n. pop = if_read & if_read_ce & if_empty_n. Requests that are not qualified are ignored and leave all state unchanged.
- Storage is DEPTH entries of DATA_WIDTH. On push, every entry shifts up one position (entry i moves to i+1) and if_din is written to entry 0. On no push, storage holds. Storage is not reset.
- The occupancy register count (ADDR_WIDTH+1 bits) updates as follows:
  - push only: count+1
  - pop only: count−1
  - push and pop together, or neither: unchanged
- The read address register addr always points to the oldest entry:
  - push only with count>0: addr+1
  - pop only with count>1: addr−1
  - all other cases: addr holds
  - addr = 0 whenever count ≤ 1
- if_dout = storage[addr], combinational from registered state. Its value is don't-care while if_empty_n=0.
- if_empty_n and if_full_n are registered, and are equivalent to count≠0 and count≠DEPTH at the next edge.
- if_num_data_valid = count.
- Boundary conditions:
  - Full: a write is blocked because if_full_n=0. A simultaneous pop proceeds, and if_full_n rises next cycle.
  - Empty: a read is blocked because if_empty_n=0. A simultaneous push proceeds, and if_empty_n rises next cycle.
  - Push and pop at count=1: the new word lands in entry 0, the old word is consumed, addr stays 0, and count stays 1.
  - Push and pop at count=DEPTH cannot occur, because the push is blocked.

## Timing
- Reset values, one cycle after reset is sampled high:
  - count=0, addr=0
  - if_empty_n=0, if_full_n=1
  - if_num_data_valid=0
  - if_dout is don't-care
- Reset takes priority over push and pop in the same cycle. Mid-operation reset discards all stored words; stale storage contents must never be presented with if_empty_n=1.
- Write-to-read latency is 1 cycle. A push at edge N makes if_empty_n=1 and if_dout=that word visible after edge N.
- A pop at edge N presents the next-oldest word after edge N, giving a throughput of 1 word per cycle on each side.
- Flag update: if_full_n falls after the edge that makes count=DEPTH, and rises after the first pop from full.
- Deasserting either ce freezes that side's request only; the other side continues to operate.

## Test plan
- Reset, then idle: if_empty_n=0, if_full_n=1, if_num_data_valid=0; hold reset 3 cycles with if_write=1, and no word is stored.
- Write 0xA, then 0xB, with no reads: if_full_n=0 after the second edge and if_num_data_valid=2. A third write of 0xC is ignored. Reads return 0xA then 0xB, and if_empty_n=0 after the second read.
- Continuous streaming, 100 words 0..99, with if_write=if_read=1 every cycle after the first word: the output sequence is 0..99 in order, count stays at 1, and there are no stalls.
- Random if_write/if_read/ce patterns over 10k cycles against a queue model: every if_dout with if_empty_n=1 matches the model head, and flags and if_num_data_valid match the model each cycle.
- Full FIFO (0x1, 0x2) with simultaneous write 0x3 and read: 0x1 is consumed, 0x3 is not stored, and count=1 with if_dout=0x2.
- Reset asserted with FIFO full: the next cycle shows if_empty_n=0, if_full_n=1, count=0; then a write of 0x55 reads back 0x55.
